// File: rtl/nn_pkg.sv
// Shared neural-network pipeline types: collector FSM states and the default result width.
package nn_pkg;

    localparam int unsigned NN_DWIDTH = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } nn_state_e;

endpackage

// File: rtl/argmax_tracker.sv
// Tracks the index of the largest signed result seen in the current layer; ties keep the lowest index.
module argmax_tracker #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              upd,
    input  logic              first,
    input  logic [AWIDTH-1:0] idx,
    input  logic [DWIDTH-1:0] data,
    output logic [AWIDTH-1:0] max_idx
);

    logic [DWIDTH-1:0] max_val;
    logic              take_c;

    // The first result of a layer always wins, which clears the previous layer's maximum.
    assign take_c = upd && (first || ($signed(data) > $signed(max_val)));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (take_c) begin
            max_val <= data;
            max_idx <= idx;
        end
    end

endmodule

// File: rtl/neuron_out_collector.sv
// Collects one layer of neuron results into the next-layer RAM and holds layer_valid until acknowledged.
// Optional feature: define NEURON_ARGMAX_EN to add the class_idx/class_valid argmax outputs.
module neuron_out_collector
    import nn_pkg::*;
#(
    parameter int unsigned DWIDTH     = NN_DWIDTH,
    parameter int unsigned NUM_NEURON = 2,
    parameter int unsigned AWIDTH     = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              neuron_done,
    input  logic [DWIDTH-1:0] neuron_out,
    input  logic              layer_ack,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              layer_valid,
    output logic              overflow
`ifdef NEURON_ARGMAX_EN
    ,
    output logic [AWIDTH-1:0] class_idx,
    output logic              class_valid
`endif
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(NUM_NEURON - 1);

    nn_state_e         state_q, state_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic              accept_c;
    logic              last_c;

    logic              wr_en_d;
    logic [AWIDTH-1:0] wr_addr_d;
    logic [DWIDTH-1:0] wr_data_d;
    logic              layer_valid_d;
    logic              overflow_d;

    assign accept_c = neuron_done && (state_q == COLLECT);
    assign last_c   = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    idx_d = last_c ? '0 : idx_q + AWIDTH'(1);
                    if (last_c) state_d = HOLD;
                end
            end
            HOLD: begin
                if (layer_ack) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output decode; write address/data hold their last values between writes
    always_comb begin
        wr_en_d       = accept_c;
        wr_addr_d     = wr_addr;
        wr_data_d     = wr_data;
        layer_valid_d = (state_d == HOLD);
        overflow_d    = overflow || (neuron_done && (state_q == HOLD));
        if (accept_c) begin
            wr_addr_d = idx_q;
            wr_data_d = neuron_out;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            layer_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_en       <= wr_en_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            layer_valid <= layer_valid_d;
            overflow    <= overflow_d;
        end
    end

`ifdef NEURON_ARGMAX_EN
    // The maximum settles on the same edge as the last write, so it is valid alongside layer_valid.
    argmax_tracker #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_argmax (
        .clk     (clk),
        .nreset  (nreset),
        .upd     (accept_c),
        .first   (idx_q == '0),
        .idx     (idx_q),
        .data    (neuron_out),
        .max_idx (class_idx)
    );

    assign class_valid = layer_valid;
`endif

endmodule

// File: doc/neuron_out_collector.md
NEURON_OUT_COLLECTOR -- requirements
Module: neuron_out_collector

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, neuron result width (signed fixed point).
REQ-002 SHALL have parameter NUM_NEURON, default 2, neuron results per layer.
REQ-003 SHALL have parameter AWIDTH, default 4, write-address width; NUM_NEURON <= 2**AWIDTH.
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port neuron_done  input  1  one-cycle strobe: neuron_out valid.
REQ-007 SHALL have port neuron_out  input  DWIDTH  neuron result, sampled when neuron_done=1.
REQ-008 SHALL have port layer_ack  input  1  downstream accepts the completed layer.
REQ-009 SHALL have port wr_en  output  1  next-layer data RAM write enable.
REQ-010 SHALL have port wr_addr  output  AWIDTH  RAM write address.
REQ-011 SHALL have port wr_data  output  DWIDTH  RAM write data.
REQ-012 SHALL have port layer_valid  output  1  all NUM_NEURON results written; held until layer_ack.
REQ-013 SHALL have port overflow  output  1  sticky: a result arrived while layer_valid=1.

Function
REQ-014 SHALL use FSM states COLLECT and HOLD; reset state COLLECT.
REQ-015 In COLLECT, neuron_done=1 SHALL register neuron_out and drive wr_en=1, wr_data=captured value, wr_addr=neuron index on the next cycle (latency 1).
REQ-016 Neuron index SHALL start at 0, increment by 1 per accepted result, return to 0 after NUM_NEURON-1.
REQ-017 Acceptance of result NUM_NEURON-1 SHALL move FSM to HOLD; layer_valid SHALL rise in the same cycle as that result's wr_en.
REQ-018 In HOLD, layer_valid SHALL stay 1 until a cycle with layer_ack=1; FSM then returns to COLLECT and layer_valid falls the next cycle.
REQ-019 In HOLD, neuron_done=1 SHALL NOT write (wr_en=0), SHALL drop the data and set overflow=1; overflow clears only on reset.
REQ-020 neuron_done and layer_ack in the same HOLD cycle: ack SHALL take effect, the result SHALL be dropped, overflow SHALL be set.
REQ-021 layer_ack in COLLECT SHALL be ignored.
REQ-022 Back-to-back neuron_done strobes SHALL each produce one write, consecutive addresses, no bubbles.
REQ-023 wr_en SHALL be 1 for exactly one cycle per accepted result; wr_addr/wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-024 nreset=0 SHALL force FSM=COLLECT, index=0, wr_en=0, wr_addr=0, wr_data=0, layer_valid=0, overflow=0, class_idx=0, class_valid=0 immediately.
REQ-025 Reset mid-layer SHALL discard the partial layer; the first result after release SHALL go to address 0.

Configuration
REQ-026 With macro NEURON_ARGMAX_EN defined, SHALL add outputs class_idx (AWIDTH) and class_valid (1): index of the maximum signed neuron_out in the layer, ties keep lowest index, valid with layer_valid.
REQ-027 Without NEURON_ARGMAX_EN, class_idx/class_valid and the comparator SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 The FSM state enum and default DWIDTH SHALL live in shared package nn_pkg.
REQ-029 Argmax logic SHALL be sub-module argmax_tracker (clear on first neuron of layer, compare-update per accepted result), instantiated only under NEURON_ARGMAX_EN.

Verification
REQ-030 NUM_NEURON=2: strobes with 0x00200000, 0xFFE00000 on consecutive cycles -> writes (addr0,0x00200000), (addr1,0xFFE00000) one cycle later each; layer_valid=1 with second write.
REQ-031 Hold layer_ack low 5 cycles, then pulse -> layer_valid high throughout, low the cycle after ack; next strobe writes addr 0.
REQ-032 Strobe 0x1 during HOLD -> no wr_en, overflow=1 and stays 1 through later layers.
REQ-033 nreset asserted after first result of a layer -> outputs zero; after release a strobe of 0x5 writes addr 0.
REQ-034 NEURON_ARGMAX_EN, NUM_NEURON=4, results -3, 7, 7, 2 -> class_idx=1, class_valid=1 with layer_valid.
REQ-035 neuron_done and layer_ack in same HOLD cycle -> ack honoured, data dropped, overflow=1.
